// File: rtl/fp_std_pkg.sv
// Shared definitions for the 24-bit float add/sub pipeline:
// 1 sign bit, 8-bit biased exponent, 15-bit mantissa.
package fp_std_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 15;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
  localparam int FP_BIAS = 127;

  localparam logic [23:0] FP_QNAN = 24'h7FC000;
  localparam logic [23:0] FP_ZERO = 24'h000000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp24_t;

endpackage

// File: rtl/fp_lzc16.sv
// Combinational leading-zero counter for a 16-bit word; all-zero input reads 16.
module fp_lzc16 (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);

  // Scan from LSB upward so the most significant set bit wins last.
  always_comb begin
    o_count = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (i_data[i]) begin
        o_count = 5'(15 - i);
      end
    end
  end

endmodule

// File: rtl/fp_std_1.sv
// Consumer stage of the 24-bit float add/sub pipeline: picks add or subtract,
// normalises, resolves specials and overflow, and packs the truncated result.
module fp_std_1
  import fp_std_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [16:0]      add_result_mantissa_i,
  input  logic [15:0]      sub_result_mantissa_i,
  input  logic             max_sign_i,
  input  logic             min_sign_i,
  input  logic [7:0]       max_exponent_i,
  input  logic [WIDTH-1:0] max_result_i,
  input  logic [WIDTH-1:0] min_result_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  logic             w_en;
  logic [4:0]       w_lz;
  logic             r_validA;
  logic             r_validB;
  logic [16:0]      r_addMan;
  logic [15:0]      r_subMan;
  logic [7:0]       r_maxExp;
  logic             r_maxSign;
  logic             r_effSub;
  logic             r_isSpecial;
  logic             r_isNan;
  logic [4:0]       r_lz;
  logic [WIDTH-1:0] r_maxResult;
  logic [WIDTH-1:0] r_result;
  fp24_t            w_res;
  logic [8:0]       w_expInc;
  logic [8:0]       w_expSub;
  logic             w_normSub;
  logic [4:0]       w_shAmt;
  logic [15:0]      w_shifted;
  logic             w_unused;

  // Both stages advance together whenever the output slot is free or draining.
  assign w_en     = !r_validB | ready_i;
  assign ready_o  = w_en;
  assign valid_o  = r_validB;
  assign result_o = r_result;
  assign w_unused = ^{min_result_i[WIDTH-1], min_result_i[FP_MAN_W-1:0],
                      w_expSub[8], w_shifted[15]};

  fp_lzc16 u_lzc (
    .i_data  (sub_result_mantissa_i),
    .o_count (w_lz)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_validA <= 1'b0;
      r_validB <= 1'b0;
      r_result <= '0;
    end else if (w_en) begin
      r_validA <= valid_i;
      r_validB <= r_validA;
      if (r_validA) begin
        r_result <= w_res;
      end
    end
  end

  // Stage A payload only needs capturing when a bundle actually transfers.
  always_ff @(posedge clk_i) begin
    if (w_en && valid_i) begin
      r_addMan    <= add_result_mantissa_i;
      r_subMan    <= sub_result_mantissa_i;
      r_maxExp    <= max_exponent_i;
      r_maxSign   <= max_sign_i;
      r_effSub    <= max_sign_i ^ min_sign_i;
      r_lz        <= w_lz;
      r_isSpecial <= (max_exponent_i == FP_EXP_MAX);
      r_isNan     <= (max_sign_i ^ min_sign_i) &&
                     (min_result_i[WIDTH-2 -: FP_EXP_W] == FP_EXP_MAX);
      r_maxResult <= max_result_i;
    end
  end

  // Nine-bit exponent math keeps overflow and underflow from wrapping silently.
  always_comb begin
    w_res     = fp24_t'(FP_ZERO);
    w_expInc  = {1'b0, r_maxExp} + 9'd1;
    w_expSub  = {1'b0, r_maxExp} - {4'b0, r_lz};
    w_normSub = ({1'b0, r_maxExp} > {4'b0, r_lz});
    if (w_normSub) begin
      w_shAmt = r_lz;
    end else if (r_maxExp == 8'd0) begin
      w_shAmt = 5'd0;
    end else begin
      w_shAmt = 5'(r_maxExp - 8'd1);
    end
    w_shifted = r_subMan << w_shAmt;

    if (r_isSpecial) begin
      w_res = r_isNan ? fp24_t'(FP_QNAN) : fp24_t'(r_maxResult);
    end else if (!r_effSub) begin
      w_res.sign = r_maxSign;
      if (r_addMan[16]) begin
        if (w_expInc >= {1'b0, FP_EXP_MAX}) begin
          w_res.exp = FP_EXP_MAX;
          w_res.man = '0;
        end else begin
          w_res.exp = w_expInc[7:0];
          w_res.man = r_addMan[15:1];
        end
      end else if (r_maxExp == 8'd0) begin
        w_res.exp = {7'b0, r_addMan[15]};
        w_res.man = r_addMan[14:0];
      end else begin
        w_res.exp = r_maxExp;
        w_res.man = r_addMan[14:0];
      end
    end else if (r_subMan != 16'd0) begin
      // An exact cancellation falls through to the +0 default.
      w_res.sign = r_maxSign;
      w_res.exp  = w_normSub ? w_expSub[7:0] : 8'd0;
      w_res.man  = w_shifted[14:0];
    end
  end

endmodule

// File: tb/tb_fp_std_1.sv
// Self-checking bench for fp_std_1: directed corner cases plus randomised
// streams with backpressure, scored against a value-level reference model.
module tb_fp_std_1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [16:0] add_result_mantissa_i;
  logic [15:0] sub_result_mantissa_i;
  logic        max_sign_i;
  logic        min_sign_i;
  logic [7:0]  max_exponent_i;
  logic [23:0] max_result_i;
  logic [23:0] min_result_i;
  logic        valid_o;
  logic        ready_i;
  logic [23:0] result_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] addMan;
    logic [15:0] subMan;
    logic        maxSign;
    logic        minSign;
    logic [7:0]  maxExp;
    logic [23:0] maxRes;
    logic [23:0] minRes;
  } bundle_t;

  fp_std_1 #(.WIDTH(24)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .valid_i               (valid_i),
    .ready_o               (ready_o),
    .add_result_mantissa_i (add_result_mantissa_i),
    .sub_result_mantissa_i (sub_result_mantissa_i),
    .max_sign_i            (max_sign_i),
    .min_sign_i            (min_sign_i),
    .max_exponent_i        (max_exponent_i),
    .max_result_i          (max_result_i),
    .min_result_i          (min_result_i),
    .valid_o               (valid_o),
    .ready_i               (ready_i),
    .result_o              (result_o)
  );

  always #5 clk_i = ~clk_i;

  // Value-level model: normalise by repeated doubling rather than a zero count.
  function automatic logic [23:0] refModel(input bundle_t b);
    int m;
    int e;
    if (b.maxExp == 8'hFF) begin
      if ((b.maxSign != b.minSign) && (b.minRes[22:15] == 8'hFF)) return 24'h7FC000;
      return b.maxRes;
    end
    e = int'(b.maxExp);
    if (b.maxSign == b.minSign) begin
      m = int'(b.addMan);
      if (m >= 65536) begin
        m = m / 2;
        e = e + 1;
        if (e >= 255) return {b.maxSign, 8'hFF, 15'h0};
      end else if (e == 0 && m >= 32768) begin
        e = 1;
      end
    end else begin
      m = int'(b.subMan);
      if (m == 0) return 24'h000000;
      while (m < 32768 && e > 1) begin
        m = m * 2;
        e = e - 1;
      end
      if (m < 32768) e = 0;
    end
    return {b.maxSign, 8'(e), 15'(m)};
  endfunction

  function automatic bundle_t mk(input logic [16:0] a, input logic [15:0] s,
                                 input logic ms, input logic ns, input logic [7:0] e,
                                 input logic [23:0] mr, input logic [23:0] nr);
    bundle_t b;
    b.addMan = a;  b.subMan = s;  b.maxSign = ms; b.minSign = ns;
    b.maxExp = e;  b.maxRes = mr; b.minRes = nr;
    return b;
  endfunction

  function automatic bundle_t randBundle();
    bundle_t     b;
    logic [15:0] t;
    case ($urandom_range(0, 5))
      0:       b.maxExp = 8'h00;
      1:       b.maxExp = 8'h01;
      2:       b.maxExp = 8'($urandom_range(2, 20));
      3:       b.maxExp = 8'hFE;
      4:       b.maxExp = 8'hFF;
      default: b.maxExp = 8'($urandom_range(0, 254));
    endcase
    t         = 16'($urandom);
    b.addMan  = 17'($urandom);
    b.subMan  = t >> $urandom_range(0, 16);
    b.maxSign = 1'($urandom);
    b.minSign = 1'($urandom);
    b.maxRes  = 24'($urandom);
    b.minRes  = 24'($urandom);
    if ($urandom_range(0, 1) == 1) b.minRes[22:15] = 8'hFF;
    return b;
  endfunction

  task automatic driveBundle(input bundle_t b);
    valid_i               = 1'b1;
    add_result_mantissa_i = b.addMan;
    sub_result_mantissa_i = b.subMan;
    max_sign_i            = b.maxSign;
    min_sign_i            = b.minSign;
    max_exponent_i        = b.maxExp;
    max_result_i          = b.maxRes;
    min_result_i          = b.minRes;
  endtask

  task automatic driveIdle();
    valid_i = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    ready_i = 1'b0;
    driveBundle(randBundle());
    driveIdle();
    nextCycle();
    nextCycle();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o);
    end
    checks++;
    if (result_o !== 24'h0) begin
      errors++; $display("[TB] FAIL reset_result: got %h expected 000000", result_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o);
    end
    rst_i = 1'b0;
    nextCycle();
  endtask

  task automatic test_directed();
    bundle_t     vecs[10];
    logic [23:0] exps[10];
    vecs[0] = mk(17'h10000, 16'h0000, 1'b0, 1'b0, 8'h7F, 24'h3F8000, 24'h3F8000); exps[0] = 24'h400000;
    vecs[1] = mk(17'h14000, 16'h4000, 1'b0, 1'b1, 8'h7F, 24'h3FC000, 24'hBF8000); exps[1] = 24'h3F0000;
    vecs[2] = mk(17'h10000, 16'h0000, 1'b1, 1'b0, 8'h7F, 24'hBF8000, 24'h3F8000); exps[2] = 24'h000000;
    vecs[3] = mk(17'h1FFFE, 16'h0000, 1'b0, 1'b0, 8'hFE, 24'h7F7FFF, 24'h7F7FFF); exps[3] = 24'h7F8000;
    vecs[4] = mk(17'h00000, 16'h0000, 1'b0, 1'b1, 8'hFF, 24'h7F8000, 24'h7F8000); exps[4] = 24'h7FC000;
    vecs[5] = mk(17'h00000, 16'h0000, 1'b0, 1'b0, 8'hFF, 24'h7F8000, 24'h3F8000); exps[5] = 24'h7F8000;
    vecs[6] = mk(17'h0C000, 16'h0000, 1'b0, 1'b0, 8'h00, 24'h004000, 24'h008000); exps[6] = 24'h00C000;
    vecs[7] = mk(17'h00000, 16'h0100, 1'b0, 1'b1, 8'h03, 24'h018000, 24'h818000); exps[7] = 24'h000400;
    vecs[8] = mk(17'h0A000, 16'h0000, 1'b1, 1'b1, 8'h80, 24'hC01000, 24'hC01000); exps[8] = 24'hC02000;
    vecs[9] = mk(17'h00000, 16'h0000, 1'b1, 1'b0, 8'hFF, 24'hFF8000, 24'h3F8000); exps[9] = 24'hFF8000;
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      driveBundle(vecs[i]);
      nextCycle();
      driveIdle();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("[TB] FAIL dir%0d_early_valid: got %b expected 0", i, valid_o);
      end
      nextCycle();
      checks++;
      if (valid_o !== 1'b1) begin
        errors++; $display("[TB] FAIL dir%0d_valid: got %b expected 1", i, valid_o);
      end
      checks++;
      if (result_o !== exps[i]) begin
        errors++; $display("[TB] FAIL dir%0d_result: got %h expected %h", i, result_o, exps[i]);
      end
      nextCycle();
    end
  endtask

  task automatic test_backpressure();
    bundle_t     pend[$];
    logic [23:0] expq[$];
    int          stallLeft = 0;
    int          stallSeen = 0;
    int          outCount  = 0;
    bit          sawValid  = 1'b0;
    for (int k = 0; k < 3; k++) pend.push_back(randBundle());
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!sawValid && valid_o) begin
        sawValid  = 1'b1;
        stallLeft = 4;
      end
      ready_i = (stallLeft > 0) ? 1'b0 : 1'b1;
      if (pend.size() > 0) driveBundle(pend[0]);
      else driveIdle();
      #1;
      if (stallLeft > 0) begin
        stallSeen++;
        checks++;
        if (ready_o !== 1'b0) begin
          errors++; $display("[TB] FAIL bp_ready_stall: got %b expected 0", ready_o);
        end
        checks++;
        if (valid_o !== 1'b1 || expq.size() == 0 || result_o !== expq[0]) begin
          errors++;
          $display("[TB] FAIL bp_hold: got valid %b result %h expected held %h", valid_o, result_o,
                   (expq.size() > 0) ? expq[0] : 24'hx);
        end
      end else if (valid_o && ready_i) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("[TB] FAIL bp_extra_output: got %h expected none", result_o);
        end else begin
          if (result_o !== expq[0]) begin
            errors++; $display("[TB] FAIL bp_order: got %h expected %h", result_o, expq[0]);
          end
          void'(expq.pop_front());
          outCount++;
        end
      end
      if (valid_i && ready_o) begin
        expq.push_back(refModel(pend[0]));
        void'(pend.pop_front());
      end
      if (stallLeft > 0) stallLeft--;
      nextCycle();
    end
    driveIdle();
    checks++;
    if (outCount != 3) begin
      errors++; $display("[TB] FAIL bp_count: got %0d outputs expected 3", outCount);
    end
    checks++;
    if (stallSeen != 4) begin
      errors++; $display("[TB] FAIL bp_stall_cycles: got %0d expected 4", stallSeen);
    end
  endtask

  task automatic test_random();
    logic [23:0] expq[$];
    bundle_t     b;
    for (int cyc = 0; cyc < 410; cyc++) begin
      if (cyc < 400) begin
        ready_i = ($urandom_range(0, 9) < 7);
        b       = randBundle();
        if ($urandom_range(0, 9) < 7) driveBundle(b);
        else driveIdle();
      end else begin
        ready_i = 1'b1;
        driveIdle();
      end
      #1;
      checks++;
      if (ready_o !== (!valid_o || ready_i)) begin
        errors++; $display("[TB] FAIL rnd_ready: got %b expected %b", ready_o, (!valid_o || ready_i));
      end
      if (valid_o) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("[TB] FAIL rnd_extra_output: got %h expected none", result_o);
        end else begin
          if (result_o !== expq[0]) begin
            errors++; $display("[TB] FAIL rnd_result: got %h expected %h", result_o, expq[0]);
          end
          if (ready_i) void'(expq.pop_front());
        end
      end
      if (valid_i && ready_o) expq.push_back(refModel(b));
      nextCycle();
    end
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("[TB] FAIL rnd_drain: got %0d pending expected 0", expq.size());
    end
  endtask

  task automatic test_reset_midflight();
    bundle_t     b;
    logic [23:0] expd;
    ready_i = 1'b1;
    driveBundle(randBundle());
    nextCycle();
    driveBundle(randBundle());
    nextCycle();
    checks++;
    if (valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_inflight: got %b expected 1", valid_o);
    end
    driveIdle();
    ready_i = 1'b0;
    rst_i   = 1'b1;
    nextCycle();
    rst_i   = 1'b0;
    ready_i = 1'b1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_valid: got %b expected 0", valid_o);
    end
    checks++;
    if (result_o !== 24'h0) begin
      errors++; $display("[TB] FAIL rst_result: got %h expected 000000", result_o);
    end
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("[TB] FAIL rst_stale%0d: got %b expected 0", k, valid_o);
      end
    end
    b    = mk(17'h10000, 16'h0000, 1'b0, 1'b0, 8'h7F, 24'h3F8000, 24'h3F8000);
    expd = refModel(b);
    driveBundle(b);
    nextCycle();
    driveIdle();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_new_early: got %b expected 0", valid_o);
    end
    nextCycle();
    checks++;
    if (valid_o !== 1'b1 || result_o !== expd) begin
      errors++; $display("[TB] FAIL rst_new_result: got valid %b result %h expected 1 %h", valid_o, result_o, expd);
    end
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
